// File: rtl/dpram_fifo_ctrl_if.sv
// FIFO controller bus: user write/read handshake, status, error flags,
// plus the two RAM ports the controller drives and the read data it gets back.
// master = user side and RAM model, slave = the controller.
interface dpram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
);
  // User write/read side
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  // Status and errors
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  // Dual-port RAM side: port A writes, port B reads
  logic                  ram_we_a;
  logic [ADDR_WIDTH-1:0] ram_addr_a;
  logic [DATA_WIDTH-1:0] ram_din_a;
  logic                  ram_we_b;
  logic [ADDR_WIDTH-1:0] ram_addr_b;
  logic [DATA_WIDTH-1:0] ram_din_b;
  logic [DATA_WIDTH-1:0] ram_dout_b;

  modport master (
    output wr_en, wr_data, rd_en, ram_dout_b,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow, ram_we_a, ram_addr_a, ram_din_a,
           ram_we_b, ram_addr_b, ram_din_b
  );

  modport slave (
    input  wr_en, wr_data, rd_en, ram_dout_b,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow, ram_we_a, ram_addr_a, ram_din_a,
           ram_we_b, ram_addr_b, ram_din_b
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller sequencing an external true dual-port RAM
// (port A = write, port B = read, registered read with 1-cycle latency).
// Owns pointers, occupancy count, status flags and overflow/underflow.
// Optional build macro FIFO_ERR_STICKY_EN: overflow/underflow hold until rst
// instead of pulsing for one cycle.
module dpram_fifo_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int DEPTH            = 1024,
  parameter int ADDR_WIDTH       = $clog2(DEPTH),
  parameter int ALMOST_FULL_THR  = DEPTH - 2,
  parameter int ALMOST_EMPTY_THR = 2
) (
  input  logic             clk,
  input  logic             rst,
  dpram_fifo_ctrl_if.slave bus
);

  localparam int                    CW        = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]         DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_CNT    = CW'(ALMOST_FULL_THR);
  localparam logic [CW-1:0]         AE_CNT    = CW'(ALMOST_EMPTY_THR);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full, empty;
  logic wr_acc, rd_acc;
  logic ovf_evt, unf_evt;

  // Flags decode the registered count, so they describe the state after the last edge.
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // Full blocks writes and empty blocks reads regardless of the other side: no bypass.
  assign wr_acc  = bus.wr_en & ~full;
  assign rd_acc  = bus.rd_en & ~empty;
  assign ovf_evt = bus.wr_en & full;
  assign unf_evt = bus.rd_en & empty;

  // Next-state: pointer wrap for non-power-of-2 depth, count, errors, read qualifier.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc;
    overflow_d  = ovf_evt;
    underflow_d = unf_evt;

    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

`ifdef FIFO_ERR_STICKY_EN
    overflow_d  = overflow_q  | ovf_evt;
    underflow_d = underflow_q | unf_evt;
`endif
  end

  // State registers with synchronous reset; reset also drops a pending rd_valid.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Status and error outputs
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // RAM ports: A writes at wr_ptr, B always addresses rd_ptr and never writes.
  assign bus.ram_we_a   = wr_acc;
  assign bus.ram_addr_a = wr_ptr_q;
  assign bus.ram_din_a  = bus.wr_data;
  assign bus.ram_we_b   = 1'b0;
  assign bus.ram_addr_b = rd_ptr_q;
  assign bus.ram_din_b  = '0;

  // Registered RAM read data lines up with rd_valid, so it passes straight through.
  assign bus.rd_data  = bus.ram_dout_b;
  assign bus.rd_valid = rd_valid_q;

endmodule
